matmul_seq: RTL and testbench

Loop sequencer for integer matrix multiplication C = A × B with 8-bit elements and a 24-bit accumulator. It walks the i/j/k loop nest and generates data-memory addresses from running pointers, with no multipliers in the address path. It fetches A and B operands, accumulates products, and writes each C element back as three bytes. It sits beside the control unit as a data-memory requester, behind the same grant handshake that shares the data memory with the core.

---
 rtl/matmul_seq_pkg.sv | 23 ++
 rtl/matmul_seq_if.sv | 27 ++
 rtl/matmul_seq_mac.sv | 49 ++++
 rtl/matmul_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_matmul_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_seq_pkg.sv
// Shared definitions for the matmul_seq loop sequencer.
//   state_e     : sequencer FSM states
//   ACC_W       : default accumulator width (covers 255 * 255 * 255 without overflow)
//   BYTES_PER_C : bytes written per C element (little-endian)
package matmul_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_LAT_A,
    S_RD_B,
    S_LAT_B,
    S_WR0,
    S_WR1,
    S_WR2,
    S_NEXT,
    S_FIN
  } state_e;

  localparam int ACC_W       = 24;
  localparam int BYTES_PER_C = 3;

endpackage

// File: rtl/matmul_seq_if.sv
// Data-memory request interface shared with the core through a grant handshake.
//   dm_en/dm_we/dm_addr/dm_wdata : request from the master
//   dm_gnt                       : request accepted at any edge with dm_en && dm_gnt
//   dm_rdata                     : read data, valid the cycle after read acceptance
interface matmul_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              dm_en;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_en, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rdata
  );

  modport slave (
    input  dm_en, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rdata
  );

endinterface

// File: rtl/matmul_seq_mac.sv
// Unsigned multiply-accumulate for the matmul_seq datapath.
//   clock, rst : clock and asynchronous active-low reset
//   clear      : zero the accumulator (wins over en)
//   en         : add a * b into the accumulator
//   a, b       : unsigned operands
//   acc        : registered accumulator
//   acc_nxt    : value acc takes at the next edge, for registering write data early
module matmul_mac
  import matmul_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  acc_nxt
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc     = acc_q;
  assign acc_nxt = acc_d;

endmodule

// File: rtl/matmul_seq.sv
// Loop sequencer for C = A x B (8-bit elements, 24-bit accumulator).
// Walks the i/j/k loop nest with running pointers (no address multipliers),
// reads A and B over the shared data-memory port, accumulates products and
// writes each C element back as three little-endian bytes.
//   clock, rst            : clock and asynchronous active-low reset
//   start                 : job start pulse, honoured only in IDLE
//   dim_x, dim_y, dim_z   : A is X x Y, B is Y x Z, C is X x Z
//   base_a/base_b/base_c  : row-major base addresses
//   dm                    : data-memory master port (registered request)
//   busy, done, err       : status; done/err are one-cycle pulses
module matmul_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = matmul_seq_pkg::ACC_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        dim_x,
  input  logic [7:0]        dim_y,
  input  logic [7:0]        dim_z,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  matmul_seq_if.master      dm,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import matmul_seq_pkg::*;

  state_e            state_q, state_d;
  logic [7:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] bb_q, bb_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_col_q, b_col_d, b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
  logic [DATA_W-1:0] a_reg_q, a_reg_d;
  logic              dm_en_q, dm_en_d, dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              mac_clear, mac_en;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic              zero_dim;

  assign zero_dim = (dim_x == 8'd0) || (dim_y == 8'd0) || (dim_z == 8'd0);

  matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clock   (clock),
    .rst     (rst),
    .clear   (mac_clear),
    .en      (mac_en),
    .a       (a_reg_q),
    .b       (dm.dm_rdata),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    bb_d      = bb_q;
    a_row_d   = a_row_q;
    a_ptr_d   = a_ptr_q;
    b_col_d   = b_col_q;
    b_ptr_d   = b_ptr_q;
    c_ptr_d   = c_ptr_q;
    a_reg_d   = a_reg_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = dim_x;
          y_d       = dim_y;
          z_d       = dim_z;
          bb_d      = base_b;
          a_row_d   = base_a;
          a_ptr_d   = base_a;
          b_col_d   = base_b;
          b_ptr_d   = base_b;
          c_ptr_d   = base_c;
          i_d       = 8'd0;
          j_d       = 8'd0;
          k_d       = 8'd0;
          mac_clear = 1'b1;
          err_d     = zero_dim;
          state_d   = zero_dim ? S_FIN : S_RD_A;
        end
      end
      S_RD_A:  if (dm.dm_gnt) state_d = S_LAT_A;
      S_LAT_A: begin
        a_reg_d = dm.dm_rdata;
        state_d = S_RD_B;
      end
      S_RD_B:  if (dm.dm_gnt) state_d = S_LAT_B;
      S_LAT_B: begin
        mac_en  = 1'b1;
        k_d     = k_q + 8'd1;
        a_ptr_d = a_ptr_q + ADDR_W'(1);
        // Next B element of the same column is one row (Z bytes) further on.
        b_ptr_d = b_ptr_q + ADDR_W'(z_q);
        state_d = (k_q == y_q - 8'd1) ? S_WR0 : S_RD_A;
      end
      S_WR0:   if (dm.dm_gnt) state_d = S_WR1;
      S_WR1:   if (dm.dm_gnt) state_d = S_WR2;
      S_WR2:   if (dm.dm_gnt) state_d = S_NEXT;
      S_NEXT: begin
        c_ptr_d   = c_ptr_q + ADDR_W'(BYTES_PER_C);
        mac_clear = 1'b1;
        k_d       = 8'd0;
        state_d   = S_RD_A;
        if (j_q < z_q - 8'd1) begin
          j_d     = j_q + 8'd1;
          b_col_d = b_col_q + ADDR_W'(1);
          b_ptr_d = b_col_q + ADDR_W'(1);
          a_ptr_d = a_row_q;
        end else if (i_q < x_q - 8'd1) begin
          i_d     = i_q + 8'd1;
          j_d     = 8'd0;
          a_row_d = a_row_q + ADDR_W'(y_q);
          a_ptr_d = a_row_q + ADDR_W'(y_q);
          b_col_d = bb_q;
          b_ptr_d = bb_q;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request outputs are decoded from the next state so they are registered
    // and stay frozen while a request waits for its grant.
    dm_en_d    = 1'b0;
    dm_we_d    = 1'b0;
    dm_addr_d  = '0;
    dm_wdata_d = '0;
    case (state_d)
      S_RD_A: begin
        dm_en_d   = 1'b1;
        dm_addr_d = a_ptr_d;
      end
      S_RD_B: begin
        dm_en_d   = 1'b1;
        dm_addr_d = b_ptr_d;
      end
      S_WR0: begin
        dm_en_d    = 1'b1;
        dm_we_d    = 1'b1;
        dm_addr_d  = c_ptr_d;
        // Entered straight from LAT_B, so the final sum is only on acc_nxt.
        dm_wdata_d = acc_nxt[0 +: DATA_W];
      end
      S_WR1: begin
        dm_en_d    = 1'b1;
        dm_we_d    = 1'b1;
        dm_addr_d  = c_ptr_d + ADDR_W'(1);
        dm_wdata_d = acc[DATA_W +: DATA_W];
      end
      S_WR2: begin
        dm_en_d    = 1'b1;
        dm_we_d    = 1'b1;
        dm_addr_d  = c_ptr_d + ADDR_W'(2);
        dm_wdata_d = acc[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      bb_q       <= '0;
      a_row_q    <= '0;
      a_ptr_q    <= '0;
      b_col_q    <= '0;
      b_ptr_q    <= '0;
      c_ptr_q    <= '0;
      a_reg_q    <= '0;
      dm_en_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      bb_q       <= bb_d;
      a_row_q    <= a_row_d;
      a_ptr_q    <= a_ptr_d;
      b_col_q    <= b_col_d;
      b_ptr_q    <= b_ptr_d;
      c_ptr_q    <= c_ptr_d;
      a_reg_q    <= a_reg_d;
      dm_en_q    <= dm_en_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign dm.dm_en    = dm_en_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: a byte-wide memory model answers requests,
// a grant generator inserts stalls on demand, and a linear sequence of jobs
// is checked against hand-computed results and cycle counts.
module tb_matmul_seq;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  dim_x, dim_y, dim_z;
  logic [15:0] base_a, base_b, base_c;
  logic        busy, done, err;

  matmul_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dm_if ();

  matmul_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(24)) dut (
    .clock  (clock),
    .rst    (rst),
    .start  (start),
    .dim_x  (dim_x),
    .dim_y  (dim_y),
    .dim_z  (dim_z),
    .base_a (base_a),
    .base_b (base_b),
    .base_c (base_c),
    .dm     (dm_if),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:65535];
  int checks   = 0;
  int failures = 0;
  int rd_acc_cnt = 0;
  int wr_acc_cnt = 0;
  int stall_rd   = 0;
  int stall_wr   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data appears for exactly one cycle after acceptance.
  always @(posedge clock) begin
    if (dm_if.dm_en && dm_if.dm_gnt && dm_if.dm_we) begin
      mem[dm_if.dm_addr] <= dm_if.dm_wdata;
      wr_acc_cnt         <= wr_acc_cnt + 1;
    end
    if (dm_if.dm_en && dm_if.dm_gnt && !dm_if.dm_we) begin
      dm_if.dm_rdata <= mem[dm_if.dm_addr];
      rd_acc_cnt     <= rd_acc_cnt + 1;
    end else begin
      dm_if.dm_rdata <= 8'hA5;
    end
  end

  // Grant generator: stalls the second read (first RD_B) and the second
  // write (first WR1) of a job, and checks a waiting request stays frozen.
  logic        prev_wait = 1'b0;
  logic        prev_we;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wdata;
  always @(negedge clock) begin : grant_gen
    logic g;
    if (prev_wait)
      chk("stall_hold", 32'({dm_if.dm_en, dm_if.dm_we, dm_if.dm_addr, dm_if.dm_wdata}),
          32'({1'b1, prev_we, prev_addr, prev_wdata}));
    g = 1'b1;
    if (dm_if.dm_en && !dm_if.dm_we && rd_acc_cnt == 1 && stall_rd > 0) begin
      g = 1'b0;
      stall_rd--;
    end
    if (dm_if.dm_en && dm_if.dm_we && wr_acc_cnt == 1 && stall_wr > 0) begin
      g = 1'b0;
      stall_wr--;
    end
    dm_if.dm_gnt = g;
    prev_wait    = dm_if.dm_en && !g;
    prev_we      = dm_if.dm_we;
    prev_addr    = dm_if.dm_addr;
    prev_wdata   = dm_if.dm_wdata;
  end

  task automatic fill(input logic [15:0] addr, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) mem[16'(addr + 16'(i))] = v;
  endtask

  task automatic chk_c(input string tag, input logic [15:0] bc, input int idx,
                       input logic [23:0] exp);
    logic [15:0] ad;
    ad = 16'(bc + 16'(3 * idx));
    chk(tag, 32'({mem[16'(ad + 16'd2)], mem[16'(ad + 16'd1)], mem[ad]}), 32'(exp));
  endtask

  // Runs one job from a start pulse to its done pulse. Cycle 1 is the cycle
  // after the accepting edge E0. Optionally pulses start mid-job (with other
  // operands) and again in the FIN cycle; both must be ignored.
  task automatic run_job(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                         input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                         input int mid_start, input bit start_at_fin,
                         output int done_cyc, output int busy_cnt, output int en_cnt,
                         output bit err_at_done, output bit en_at1);
    int cyc;
    bit seen;
    @(negedge clock);
    rd_acc_cnt = 0;
    wr_acc_cnt = 0;
    dim_x = x; dim_y = y; dim_z = z;
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0; seen = 0; done_cyc = 0; busy_cnt = 0; en_cnt = 0;
    err_at_done = 0; en_at1 = 0;
    while (cyc < 4000 && !seen) begin
      cyc++;
      if (cyc == 1) en_at1 = dm_if.dm_en;
      if (busy) busy_cnt++;
      if (dm_if.dm_en) en_cnt++;
      if (done) begin
        seen = 1;
        done_cyc = cyc;
        err_at_done = err;
      end else begin
        if (cyc == mid_start) begin
          start = 1'b1;
          dim_x = 8'd1; dim_y = 8'd1; dim_z = 8'd1;
          base_c = 16'h0500;
        end else if (cyc == mid_start + 1) begin
          start = 1'b0;
          dim_x = x; dim_y = y; dim_z = z;
          base_c = bc;
        end
        @(negedge clock);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (start_at_fin) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("done_pulse", 32'({done, err}), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic load_2x2();
    mem[16'h0200] = 8'd1; mem[16'h0201] = 8'd2; mem[16'h0202] = 8'd3; mem[16'h0203] = 8'd4;
    mem[16'h0300] = 8'd5; mem[16'h0301] = 8'd6; mem[16'h0302] = 8'd7; mem[16'h0303] = 8'd8;
    fill(16'h0400, 12, 8'hEE);
  endtask

  task automatic chk_2x2(input string tag);
    chk_c({tag, "_c00"}, 16'h0400, 0, 24'd19);
    chk_c({tag, "_c01"}, 16'h0400, 1, 24'd22);
    chk_c({tag, "_c10"}, 16'h0400, 2, 24'd43);
    chk_c({tag, "_c11"}, 16'h0400, 3, 24'd50);
  endtask

  initial begin : main
    int dc, bcnt, ecnt, wait_cyc;
    bit ea, e1;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b0; start = 1'b0;
    dim_x = 8'd0; dim_y = 8'd0; dim_z = 8'd0;
    base_a = 16'd0; base_b = 16'd0; base_c = 16'd0;
    repeat (3) @(negedge clock);
    chk("reset_ctrl", 32'({dm_if.dm_en, dm_if.dm_we, busy, done, err}), 32'd0);
    chk("reset_bus", 32'({dm_if.dm_addr, dm_if.dm_wdata}), 32'd0);
    rst = 1'b1;
    @(negedge clock);

    // 1x1x1: 3 * 5 = 15, nine cycles from first busy to done.
    mem[16'h0010] = 8'd3;
    mem[16'h0020] = 8'd5;
    fill(16'h0100, 3, 8'hEE);
    run_job(8'd1, 8'd1, 8'd1, 16'h0010, 16'h0020, 16'h0100, 0, 0, dc, bcnt, ecnt, ea, e1);
    chk("t1_en_cycle1", 32'(e1), 32'd1);
    chk("t1_done_cyc", 32'(dc), 32'd9);
    chk("t1_busy_cnt", 32'(bcnt), 32'd9);
    chk("t1_err", 32'(ea), 32'd0);
    chk("t1_writes", 32'(wr_acc_cnt), 32'd3);
    chk_c("t1_c", 16'h0100, 0, 24'h00000F);

    // 2x2x2: C = [[19,22],[43,50]], 4*(4*2+4)+1 = 49 cycles.
    load_2x2();
    run_job(8'd2, 8'd2, 8'd2, 16'h0200, 16'h0300, 16'h0400, 0, 0, dc, bcnt, ecnt, ea, e1);
    chk("t2_done_cyc", 32'(dc), 32'd49);
    chk("t2_writes", 32'(wr_acc_cnt), 32'd12);
    chk_2x2("t2");

    // Max accumulate: 255 * 255 * 255 = 0xFD02FF, 255*4+4+1 = 1025 cycles.
    fill(16'h1000, 255, 8'hFF);
    fill(16'h2000, 255, 8'hFF);
    fill(16'h3000, 3, 8'hEE);
    run_job(8'd1, 8'd255, 8'd1, 16'h1000, 16'h2000, 16'h3000, 0, 0, dc, bcnt, ecnt, ea, e1);
    chk("t3_done_cyc", 32'(dc), 32'd1025);
    chk_c("t3_c", 16'h3000, 0, 24'hFD02FF);

    // Stalls: 3 cycles on first RD_B, 2 on first WR1 -> 5 extra cycles.
    load_2x2();
    stall_rd = 3;
    stall_wr = 2;
    run_job(8'd2, 8'd2, 8'd2, 16'h0200, 16'h0300, 16'h0400, 0, 0, dc, bcnt, ecnt, ea, e1);
    chk("t4_done_cyc", 32'(dc), 32'd54);
    chk("t4_stalls_used", 32'(stall_rd + stall_wr), 32'd0);
    chk_2x2("t4");

    // Zero dimension: no requests, done and err together in cycle 1.
    run_job(8'd2, 8'd0, 8'd2, 16'h0200, 16'h0300, 16'h0400, 0, 0, dc, bcnt, ecnt, ea, e1);
    chk("t5_done_cyc", 32'(dc), 32'd1);
    chk("t5_err", 32'(ea), 32'd1);
    chk("t5_en_cnt", 32'(ecnt), 32'd0);
    chk("t5_busy_cnt", 32'(bcnt), 32'd1);

    // Reset asserted while the first WR1 request is pending.
    load_2x2();
    @(negedge clock);
    rd_acc_cnt = 0;
    wr_acc_cnt = 0;
    dim_x = 8'd2; dim_y = 8'd2; dim_z = 8'd2;
    base_a = 16'h0200; base_b = 16'h0300; base_c = 16'h0400;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_cyc = 0;
    while (!(dm_if.dm_en && dm_if.dm_we && wr_acc_cnt == 1) && wait_cyc < 200) begin
      @(negedge clock);
      wait_cyc++;
    end
    chk("t6_reached_wr1", 32'(wait_cyc < 200), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_ctrl", 32'({dm_if.dm_en, dm_if.dm_we, busy, done, err}), 32'd0);
    chk("t6_rst_bus", 32'({dm_if.dm_addr, dm_if.dm_wdata}), 32'd0);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    chk("t6_idle_after_rst", 32'({dm_if.dm_en, busy}), 32'd0);
    load_2x2();
    run_job(8'd2, 8'd2, 8'd2, 16'h0200, 16'h0300, 16'h0400, 0, 0, dc, bcnt, ecnt, ea, e1);
    chk("t6_done_cyc", 32'(dc), 32'd49);
    chk_2x2("t6");

    // start pulsed mid-job with other operands, and again in the FIN cycle.
    load_2x2();
    fill(16'h0500, 3, 8'hEE);
    run_job(8'd2, 8'd2, 8'd2, 16'h0200, 16'h0300, 16'h0400, 10, 1, dc, bcnt, ecnt, ea, e1);
    chk("t7_done_cyc", 32'(dc), 32'd49);
    chk("t7_writes", 32'(wr_acc_cnt), 32'd12);
    chk_2x2("t7");
    chk_c("t7_untouched", 16'h0500, 0, 24'hEEEEEE);
    repeat (2) @(negedge clock);
    chk("t7_still_idle", 32'({dm_if.dm_en, busy}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
